load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the data/address width; only 32 is supported.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum WAIT cycles before a bus error; legal range 1..255.
REQ-003 SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit, a synchronous active-high reset.
REQ-005 SHALL have port read_enable_i, input, 1 bit, a load request from the core.
REQ-006 SHALL have port write_enable_i, input, 1 bit, a store request from the core.
REQ-007 SHALL have port funct3_i, input, 3 bits, the access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 SHALL have port addr_i, input, WIDTH bits, the byte address (ALU result).
REQ-009 SHALL have port write_data_i, input, WIDTH bits, the store data (rs2), right-aligned.
REQ-010 SHALL have port read_data_o, output, WIDTH bits, the formatted load data.
REQ-011 SHALL have port busy_o, output, 1 bit, the core stall request.
REQ-012 SHALL have port bus_err_o, output, 1 bit, a one-cycle error pulse.
REQ-013 SHALL have port mem_req_o, output, 1 bit, the memory request valid.
REQ-014 SHALL have port mem_we_o, output, 1 bit, the memory write enable.
REQ-015 SHALL have port mem_addr_o, output, WIDTH bits, the word-aligned address (bits [1:0]=0).
REQ-016 SHALL have port mem_wdata_o, output, WIDTH bits, the lane-shifted store data.
REQ-017 SHALL have port mem_be_o, output, 4 bits, the byte enables.
REQ-018 SHALL have port mem_ready_i, input, 1 bit, memory completion; qualifies mem_rdata_i.
REQ-019 SHALL have port mem_rdata_i, input, WIDTH bits, the memory read word.

Function
REQ-020 SHALL implement FSM states IDLE, WAIT and DONE.
REQ-021 In IDLE with (read_enable_i|write_enable_i): busy_o=1 and mem_req_o=1 combinationally; mem_ready_i=1 -> DONE, else -> WAIT.
REQ-022 In WAIT: mem_req_o, mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o SHALL be held from registered request copies; busy_o=1; mem_ready_i -> DONE.
REQ-023 In DONE: busy_o=0, mem_req_o=0; next state IDLE unconditionally, so the core advances exactly one instruction.
REQ-024 Minimum access latency SHALL be 2 cycles (IDLE+DONE) with zero-wait memory, and 2+N cycles with N wait cycles.
REQ-025 read_enable_i and write_enable_i both high SHALL be treated as a store.
REQ-026 Byte enables SHALL be: B=0001<<addr[1:0]; H=0011<<addr[1]*2; W=1111.
REQ-027 Store data SHALL be replicated into the selected lanes: B -> {4{b}}, H -> {2{h}}.
REQ-028 Load data SHALL be captured on mem_ready_i, lane-selected by the registered addr[1:0], and sign-extended (B/H) or zero-extended (BU/HU); it SHALL be held on read_data_o until the next load completes.
REQ-029 A counter SHALL count WAIT cycles; on reaching TIMEOUT_CYCLES the FSM SHALL go to DONE, pulse bus_err_o for one cycle, and read_data_o SHALL become 0.
REQ-030 The counter SHALL clear on entry to WAIT.
REQ-031 mem_ready_i in IDLE or DONE without a pending request SHALL be ignored.
REQ-032 Unsupported funct3 values SHALL be treated as W.

Reset
REQ-033 rst_i SHALL force state IDLE, counter 0, read_data_o=0, bus_err_o=0 and the registered request to 0.
REQ-034 While rst_i=1, busy_o and mem_req_o SHALL be 0.
REQ-035 Reset during WAIT or DONE SHALL abandon the access, and a late mem_ready_i SHALL be ignored.

Configuration
REQ-036 Macro LSU_MISALIGN_TRAP_EN defined: an H access with addr[0]=1, or a W access with addr[1:0]!=0, SHALL issue no mem_req_o, go IDLE->DONE with busy_o=1 for one cycle, and pulse bus_err_o.
REQ-037 Macro LSU_MISALIGN_TRAP_EN undefined: the offending low address bits SHALL be ignored (forced aligned) and the access performed normally.

Verification
REQ-038 Zero-wait SW to addr 0x10, data 0xDEADBEEF -> mem_addr_o=0x10, mem_be_o=1111, busy_o high 1 cycle, DONE next.
REQ-039 SB of 0xAB to 0x13 -> mem_be_o=1000, mem_wdata_o=0xABABABAB.
REQ-040 LB from 0x12 with mem_rdata_i=0x0080FF00, 3 wait cycles -> busy_o high 4 cycles, read_data_o=0xFFFFFF80; LBU -> 0x00000080.
REQ-041 mem_ready_i never asserted, TIMEOUT_CYCLES=4 -> bus_err_o pulse after 4 WAIT cycles, read_data_o=0, FSM returns to IDLE.
REQ-042 LW to 0x06: with LSU_MISALIGN_TRAP_EN -> no mem_req_o, bus_err_o pulse; without -> mem_addr_o=0x04.
REQ-043 rst_i asserted mid-WAIT, then mem_ready_i=1 -> state IDLE, read_data_o stays 0, busy_o=0.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if -- word-wide memory bus between the load/store unit
// and the data memory.
//
// Signals:
//   mem_req_o    request valid (driven by the LSU)
//   mem_we_o     write enable (driven by the LSU)
//   mem_addr_o   word-aligned byte address, bits [1:0] always 0 (driven by the LSU)
//   mem_wdata_o  store data already replicated into the byte lanes (driven by the LSU)
//   mem_be_o     byte enables, one per byte lane (driven by the LSU)
//   mem_ready_i  completion strobe; qualifies mem_rdata_i (driven by the memory)
//   mem_rdata_i  read word (driven by the memory)
//
// Modports:
//   master  the load/store unit side
//   slave   the memory side
interface load_store_unit_if #(
  parameter int WIDTH = 32
);
  logic             mem_req_o;
  logic             mem_we_o;
  logic [WIDTH-1:0] mem_addr_o;
  logic [WIDTH-1:0] mem_wdata_o;
  logic [3:0]       mem_be_o;
  logic             mem_ready_i;
  logic [WIDTH-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_addr_o,
    output mem_wdata_o,
    output mem_be_o,
    input  mem_ready_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_addr_o,
    input  mem_wdata_o,
    input  mem_be_o,
    output mem_ready_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit -- RV32-style load/store unit sitting between the core
// and a word-wide data memory with a ready handshake.
//
// The core raises read_enable_i or write_enable_i and is stalled through
// busy_o until the access finishes. A zero-wait access takes two cycles
// (IDLE, DONE); each memory wait cycle adds one cycle in WAIT. A WAIT that
// lasts TIMEOUT_CYCLES cycles is abandoned with a one-cycle bus_err_o pulse
// and the load result is cleared to 0.
//
// Parameters:
//   WIDTH           data/address width (only 32 is supported)
//   TIMEOUT_CYCLES  WAIT cycles before a bus error, 1..255
//
// Ports:
//   clk_i           clock, rising edge
//   rst_i           synchronous active-high reset
//   read_enable_i   load request
//   write_enable_i  store request (wins when both requests are high)
//   funct3_i        access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; others act as W
//   addr_i          byte address
//   write_data_i    right-aligned store data
//   read_data_o     formatted load data, held until the next load completes
//   busy_o          stall request to the core
//   bus_err_o       one-cycle error pulse
//   mem             memory bus (load_store_unit_if.master)
//
// Build option:
//   LSU_MISALIGN_TRAP_EN  when defined, a misaligned H or W access issues no
//                         memory request and pulses bus_err_o; when undefined
//                         the offending low address bits are ignored.
module load_store_unit #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               read_enable_i,
  input  logic               write_enable_i,
  input  logic [2:0]         funct3_i,
  input  logic [WIDTH-1:0]   addr_i,
  input  logic [WIDTH-1:0]   write_data_i,
  output logic [WIDTH-1:0]   read_data_o,
  output logic               busy_o,
  output logic               bus_err_o,
  load_store_unit_if.master  mem
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t state, state_next;

  logic [7:0]       wait_cnt;
  logic             req_we_q;
  logic [WIDTH-1:0] req_addr_q;
  logic [WIDTH-1:0] req_wdata_q;
  logic [3:0]       req_be_q;
  logic [2:0]       req_funct3_q;
  logic [1:0]       req_off_q;

  logic             access;
  size_t            size_in;
  logic [1:0]       off_in;
  logic [3:0]       be_in;
  logic [WIDTH-1:0] wdata_in;
  logic             trap_cond;

  logic             take_req;
  logic             capture_load;
  logic             timeout;
  logic             trap;
  logic [WIDTH-1:0] load_value;

  // Picks the addressed lane out of the memory word and sign- or
  // zero-extends it; anything that is not a B/H variant is a full word.
  function automatic logic [WIDTH-1:0] format_load(input logic [WIDTH-1:0] word,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  format_load = {{24{b[7]}}, b};
      3'b100:  format_load = {24'b0, b};
      3'b001:  format_load = {{16{h[15]}}, h};
      3'b101:  format_load = {16'b0, h};
      default: format_load = word;
    endcase
  endfunction

  assign access = read_enable_i | write_enable_i;

  // Decode the incoming request into lane offset, byte enables and
  // lane-replicated store data. The offset already discards the address
  // bits that a halfword or word access cannot use.
  always_comb begin
    size_in  = SZ_W;
    off_in   = 2'b00;
    be_in    = 4'b1111;
    wdata_in = write_data_i;
    case (funct3_i)
      3'b000, 3'b100: size_in = SZ_B;
      3'b001, 3'b101: size_in = SZ_H;
      default:        size_in = SZ_W;
    endcase
    case (size_in)
      SZ_B: begin
        off_in   = addr_i[1:0];
        be_in    = 4'b0001 << addr_i[1:0];
        wdata_in = {4{write_data_i[7:0]}};
      end
      SZ_H: begin
        off_in   = {addr_i[1], 1'b0};
        be_in    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_in = {2{write_data_i[15:0]}};
      end
      default: begin
        off_in   = 2'b00;
        be_in    = 4'b1111;
        wdata_in = write_data_i;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_cond = ((size_in == SZ_H) && addr_i[0]) ||
                     ((size_in == SZ_W) && (addr_i[1:0] != 2'b00));
`else
  assign trap_cond = 1'b0;
`endif

  // Next state and bus outputs. In IDLE the bus mirrors the core inputs so
  // a zero-wait memory can answer in the same cycle; in WAIT and DONE it is
  // driven from the captured request so the core may change its inputs.
  always_comb begin
    state_next      = state;
    busy_o          = 1'b0;
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = req_we_q;
    mem.mem_addr_o  = req_addr_q;
    mem.mem_be_o    = req_be_q;
    mem.mem_wdata_o = req_wdata_q;
    take_req        = 1'b0;
    capture_load    = 1'b0;
    timeout         = 1'b0;
    trap            = 1'b0;
    load_value      = format_load(mem.mem_rdata_i, req_funct3_q, req_off_q);

    case (state)
      IDLE: begin
        mem.mem_we_o    = write_enable_i;
        mem.mem_addr_o  = {addr_i[WIDTH-1:2], 2'b00};
        mem.mem_be_o    = be_in;
        mem.mem_wdata_o = wdata_in;
        if (access) begin
          busy_o = 1'b1;
          if (trap_cond) begin
            trap       = 1'b1;
            state_next = DONE;
          end else begin
            mem.mem_req_o = 1'b1;
            take_req      = 1'b1;
            if (mem.mem_ready_i) begin
              state_next   = DONE;
              capture_load = ~write_enable_i;
              load_value   = format_load(mem.mem_rdata_i, funct3_i, off_in);
            end else begin
              state_next = WAIT;
            end
          end
        end
      end
      WAIT: begin
        busy_o        = 1'b1;
        mem.mem_req_o = 1'b1;
        if (mem.mem_ready_i) begin
          state_next   = DONE;
          capture_load = ~req_we_q;
        end else if (wait_cnt == CNT_LAST) begin
          state_next = DONE;
          timeout    = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (rst_i) begin
      busy_o        = 1'b0;
      mem.mem_req_o = 1'b0;
    end
  end

  // State, wait counter, captured request and load result. The counter is
  // cleared on the IDLE->WAIT step and counts every WAIT cycle after that.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      wait_cnt     <= 8'd0;
      read_data_o  <= '0;
      bus_err_o    <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_be_q     <= 4'b0000;
      req_funct3_q <= 3'b000;
      req_off_q    <= 2'b00;
    end else begin
      state     <= state_next;
      bus_err_o <= timeout | trap;

      if (state == WAIT) begin
        wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= 8'd0;
      end

      if (take_req) begin
        req_we_q     <= write_enable_i;
        req_addr_q   <= {addr_i[WIDTH-1:2], 2'b00};
        req_wdata_q  <= wdata_in;
        req_be_q     <= be_in;
        req_funct3_q <= funct3_i;
        req_off_q    <= off_in;
      end

      if (capture_load) begin
        read_data_o <= load_value;
      end else if (timeout) begin
        read_data_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit -- directed self-checking bench for load_store_unit.
// Inputs are driven on the falling clock edge and outputs are checked 1ns
// later, away from the rising edge. The memory side is driven directly
// through the interface instance. Built with TIMEOUT_CYCLES=4.
module tb_load_store_unit;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        read_enable_i;
  logic        write_enable_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic        busy_o;
  logic        bus_err_o;

  int total = 0;
  int bad   = 0;

  load_store_unit_if #(.WIDTH(WIDTH)) mem_bus ();

  load_store_unit #(
    .WIDTH(WIDTH),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .read_enable_i(read_enable_i),
    .write_enable_i(write_enable_i),
    .funct3_i(funct3_i),
    .addr_i(addr_i),
    .write_data_i(write_data_i),
    .read_data_o(read_data_o),
    .busy_o(busy_o),
    .bus_err_o(bus_err_o),
    .mem(mem_bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic re, input logic we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic ready, input logic [31:0] rdata);
    read_enable_i         = re;
    write_enable_i        = we;
    funct3_i              = f3;
    addr_i                = addr;
    write_data_i          = wd;
    mem_bus.mem_ready_i   = ready;
    mem_bus.mem_rdata_i   = rdata;
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 1'b0, 32'h0);
    step();
    step();
    #1;
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_mem_req", mem_bus.mem_req_o, 0);
    checkOutput("rst_read_data", read_data_o, 0);
    checkOutput("rst_bus_err", bus_err_o, 0);

    // SW 0xDEADBEEF to 0x10, zero wait
    step();
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b1, 32'h0);
    #1;
    checkOutput("sw_busy", busy_o, 1);
    checkOutput("sw_req", mem_bus.mem_req_o, 1);
    checkOutput("sw_we", mem_bus.mem_we_o, 1);
    checkOutput("sw_addr", mem_bus.mem_addr_o, 32'h10);
    checkOutput("sw_be", mem_bus.mem_be_o, 4'b1111);
    checkOutput("sw_wdata", mem_bus.mem_wdata_o, 32'hDEADBEEF);
    step();
    #1;
    checkOutput("sw_done_busy", busy_o, 0);
    checkOutput("sw_done_req", mem_bus.mem_req_o, 0);

    // SB 0xAB to 0x13
    step();
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h13, 32'h000000AB, 1'b1, 32'h0);
    #1;
    checkOutput("sb_be", mem_bus.mem_be_o, 4'b1000);
    checkOutput("sb_wdata", mem_bus.mem_wdata_o, 32'hABABABAB);
    checkOutput("sb_addr", mem_bus.mem_addr_o, 32'h10);
    step();

    // SH 0x1234 to 0x16
    step();
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h16, 32'h00001234, 1'b1, 32'h0);
    #1;
    checkOutput("sh_be", mem_bus.mem_be_o, 4'b1100);
    checkOutput("sh_wdata", mem_bus.mem_wdata_o, 32'h12341234);
    checkOutput("sh_addr", mem_bus.mem_addr_o, 32'h14);
    step();

    // LB from 0x12 with three wait cycles; core inputs scrambled in WAIT
    step();
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h12, 32'h0, 1'b0, 32'h0);
    #1;
    checkOutput("lb_idle_busy", busy_o, 1);
    checkOutput("lb_idle_we", mem_bus.mem_we_o, 0);
    checkOutput("lb_idle_be", mem_bus.mem_be_o, 4'b0100);
    step();
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h33, 32'h5555AAAA, 1'b0, 32'h0);
    #1;
    checkOutput("lb_w1_busy", busy_o, 1);
    checkOutput("lb_w1_req", mem_bus.mem_req_o, 1);
    checkOutput("lb_w1_addr", mem_bus.mem_addr_o, 32'h10);
    checkOutput("lb_w1_be", mem_bus.mem_be_o, 4'b0100);
    checkOutput("lb_w1_we", mem_bus.mem_we_o, 0);
    step();
    #1;
    checkOutput("lb_w2_busy", busy_o, 1);
    step();
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h33, 32'h5555AAAA, 1'b1, 32'h0080FF00);
    #1;
    checkOutput("lb_w3_busy", busy_o, 1);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'h0);
    #1;
    checkOutput("lb_done_busy", busy_o, 0);
    checkOutput("lb_done_req", mem_bus.mem_req_o, 0);
    checkOutput("lb_data", read_data_o, 32'hFFFFFF80);
    step();
    #1;
    checkOutput("stray_ready_busy", busy_o, 0);
    checkOutput("stray_ready_req", mem_bus.mem_req_o, 0);
    checkOutput("stray_ready_data", read_data_o, 32'hFFFFFF80);

    // Store between loads leaves the load result alone
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h20, 32'h11111111, 1'b1, 32'h0);
    step();
    #1;
    checkOutput("st_hold_data", read_data_o, 32'hFFFFFF80);

    // LBU / LH / LHU / unsupported funct3, zero wait
    step();
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h12, 32'h0, 1'b1, 32'h0080FF00);
    step();
    #1;
    checkOutput("lbu_data", read_data_o, 32'h00000080);
    step();
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 1'b1, 32'h80010000);
    step();
    #1;
    checkOutput("lh_data", read_data_o, 32'hFFFF8001);
    step();
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b1, 32'h80010000);
    step();
    #1;
    checkOutput("lhu_data", read_data_o, 32'h00008001);
    step();
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h08, 32'h0, 1'b1, 32'hCAFEF00D);
    #1;
    checkOutput("f3_011_be", mem_bus.mem_be_o, 4'b1111);
    step();
    #1;
    checkOutput("f3_011_data", read_data_o, 32'hCAFEF00D);

    // Timeout: memory never answers
    step();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0);
    #1;
    checkOutput("to_idle_busy", busy_o, 1);
    for (int i = 0; i < TIMEOUT; i++) begin
      step();
      #1;
      checkOutput($sformatf("to_wait%0d_busy", i), busy_o, 1);
      checkOutput($sformatf("to_wait%0d_err", i), bus_err_o, 0);
    end
    step();
    #1;
    checkOutput("to_done_err", bus_err_o, 1);
    checkOutput("to_done_busy", busy_o, 0);
    checkOutput("to_done_data", read_data_o, 32'h0);
    step();
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    checkOutput("to_err_pulse_end", bus_err_o, 0);
    checkOutput("to_back_idle_busy", busy_o, 0);

    // Misaligned LW to 0x06
    step();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h06, 32'h0, 1'b1, 32'h11223344);
    #1;
`ifdef LSU_MISALIGN_TRAP_EN
    checkOutput("mis_req", mem_bus.mem_req_o, 0);
    checkOutput("mis_busy", busy_o, 1);
    step();
    #1;
    checkOutput("mis_err", bus_err_o, 1);
    checkOutput("mis_done_busy", busy_o, 0);
`else
    checkOutput("mis_req", mem_bus.mem_req_o, 1);
    checkOutput("mis_addr", mem_bus.mem_addr_o, 32'h04);
    checkOutput("mis_be", mem_bus.mem_be_o, 4'b1111);
    step();
    #1;
    checkOutput("mis_data", read_data_o, 32'h11223344);
    checkOutput("mis_err", bus_err_o, 0);
`endif

    // LW gives a nonzero result, then reset lands in the middle of a WAIT
    step();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h08, 32'h0, 1'b1, 32'h12345678);
    step();
    #1;
    checkOutput("lw_data", read_data_o, 32'h12345678);
    step();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0, 32'h0);
    step();
    #1;
    checkOutput("rw_wait_busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    checkOutput("rw_rst_busy", busy_o, 0);
    checkOutput("rw_rst_req", mem_bus.mem_req_o, 0);
    step();
    rst_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 32'hFFFFFFFF);
    #1;
    checkOutput("rw_after_busy", busy_o, 0);
    checkOutput("rw_after_req", mem_bus.mem_req_o, 0);
    checkOutput("rw_after_data", read_data_o, 32'h0);
    step();
    #1;
    checkOutput("rw_late_ready_data", read_data_o, 32'h0);
    checkOutput("rw_late_ready_busy", busy_o, 0);
    checkOutput("rw_late_ready_err", bus_err_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
